// File: rtl/ising_pkg.sv
// ising_pkg -- shared definitions for the Ising spin readout block.
//   SPIN_W     : default spin vector width from the array
//   WORD_W     : default output stream word width
//   NUM_WORDS  : number of stream words needed to carry SPIN_W bits
//   state_t    : readout FSM states
//   num_words(): ceil(spin_w / word_w)
package ising_pkg;

  localparam int SPIN_W = 350;
  localparam int WORD_W = 32;

  function automatic int num_words(input int spin_w, input int word_w);
    return (spin_w + word_w - 1) / word_w;
  endfunction

  localparam int NUM_WORDS = num_words(SPIN_W, WORD_W);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ANNEAL  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_STREAM  = 3'd4
  } state_t;

endpackage

// File: rtl/ising_spin_serializer.sv
// ising_spin_serializer -- spin buffer plus word-stream serializer.
// Captures the spin vector on a one-cycle capture strobe, then presents it
// as ceil(SPIN_W/WORD_W) words (zero-padded above SPIN_W) on a valid/ready
// stream. Optional macro ISING_READOUT_POPCOUNT_EN appends one extra word
// carrying the popcount of the captured bits.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   capture       : load spin_in into the buffer and start the stream
//   spin_in       : spin vector from the array
//   dout_ready    : downstream ready
//   dout          : current stream word (zero while not valid)
//   dout_valid    : stream word valid
//   dout_last     : current word is the final one
//   last_xfer     : final word is being transferred this cycle
module ising_spin_serializer
  import ising_pkg::*;
#(
  parameter int SPIN_W = ising_pkg::SPIN_W,
  parameter int WORD_W = ising_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [SPIN_W-1:0] spin_in,
  input  logic              dout_ready,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              last_xfer
);

  localparam int NUM_WORDS = num_words(SPIN_W, WORD_W);
`ifdef ISING_READOUT_POPCOUNT_EN
  localparam int TOTAL_WORDS = NUM_WORDS + 1;
`else
  localparam int TOTAL_WORDS = NUM_WORDS;
`endif
  localparam int IDX_W = $clog2(TOTAL_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);
  localparam int PAD_W = NUM_WORDS * WORD_W;

  logic [SPIN_W-1:0] spin_buf;
  logic [IDX_W-1:0]  idx;
  logic              valid_q;
  logic [PAD_W-1:0]  padded;
  logic [WORD_W-1:0] word;

  always_ff @(posedge clk) begin
    if (rst) begin
      spin_buf <= '0;
      idx      <= '0;
      valid_q  <= 1'b0;
    end else if (capture) begin
      spin_buf <= spin_in;
      idx      <= '0;
      valid_q  <= 1'b1;
    end else if (valid_q && dout_ready) begin
      if (idx == LAST_IDX) begin
        valid_q <= 1'b0;
        idx     <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    padded               = '0;
    padded[SPIN_W-1:0]   = spin_buf;
  end

`ifdef ISING_READOUT_POPCOUNT_EN
  logic [WORD_W-1:0] popcount;

  always_comb begin
    popcount = '0;
    for (int unsigned i = 0; i < SPIN_W; i++) begin
      popcount = popcount + WORD_W'(spin_buf[i]);
    end
  end
`endif

  // Compare-select mux keeps the word index in range for the popcount slot.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (idx == IDX_W'(k)) word = padded[k*WORD_W +: WORD_W];
    end
`ifdef ISING_READOUT_POPCOUNT_EN
    if (idx == IDX_W'(NUM_WORDS)) word = popcount;
`endif
  end

  assign dout       = valid_q ? word : '0;
  assign dout_valid = valid_q;
  assign dout_last  = valid_q && (idx == LAST_IDX);
  assign last_xfer  = dout_last && dout_ready;

endmodule

// File: rtl/ising_spin_readout.sv
// ising_spin_readout -- anneal / sample / capture / stream controller for an
// oscillator-based Ising array. Optional macro ISING_READOUT_POPCOUNT_EN adds
// a trailing popcount word to the stream.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   START           : one-cycle run request (accepted in IDLE only)
//   ANNEAL_CYCLES   : oscillator-enable duration, latched on accepted START
//   ROSC_GLOBAL_EN  : array oscillator enable (ANNEAL and SAMPLE)
//   SAMPLE          : registered spin-sample strobe, SAMPLE_HOLD cycles
//   SPIN_OUT        : spin vector from the array
//   DOUT/DOUT_VALID/DOUT_READY/DOUT_LAST : output word stream
//   BUSY            : high outside IDLE
//   DONE            : high in the cycle the final word is transferred
module ising_spin_readout
  import ising_pkg::*;
#(
  parameter int SPIN_W      = ising_pkg::SPIN_W,
  parameter int WORD_W      = ising_pkg::WORD_W,
  parameter int SAMPLE_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [15:0]       ANNEAL_CYCLES,
  output logic              ROSC_GLOBAL_EN,
  output logic              SAMPLE,
  input  logic [SPIN_W-1:0] SPIN_OUT,
  output logic [WORD_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              DOUT_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [15:0] HOLD_CNT = 16'(SAMPLE_HOLD);

  state_t      state_q, state_d;
  logic [15:0] timer_q;
  logic        rosc_q, rosc_d;
  logic        sample_q, sample_d;
  logic        capture;
  logic        last_xfer;

  // State register; ROSC/SAMPLE are registered from the next state so they
  // line up exactly with the state they belong to and cannot glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      rosc_q   <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rosc_q   <= rosc_d;
      sample_q <= sample_d;
    end
  end

  // Shared down-counter: anneal length, then sample hold length.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (START) timer_q <= (ANNEAL_CYCLES == '0) ? 16'd1 : ANNEAL_CYCLES;
        ST_ANNEAL:
          timer_q <= (timer_q == 16'd1) ? HOLD_CNT : timer_q - 16'd1;
        ST_SAMPLE:
          timer_q <= timer_q - 16'd1;
        default:
          timer_q <= '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (START) state_d = ST_ANNEAL;
      ST_ANNEAL:  if (timer_q == 16'd1) state_d = ST_SAMPLE;
      ST_SAMPLE:  if (timer_q == 16'd1) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_STREAM;
      ST_STREAM:  if (last_xfer) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rosc_d   = (state_d == ST_ANNEAL) || (state_d == ST_SAMPLE);
    sample_d = (state_d == ST_SAMPLE);
  end

  assign capture        = (state_q == ST_CAPTURE);
  assign ROSC_GLOBAL_EN = rosc_q;
  assign SAMPLE         = sample_q;
  assign BUSY           = (state_q != ST_IDLE);
  assign DONE           = last_xfer;

  ising_spin_serializer #(
    .SPIN_W (SPIN_W),
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk        (CLK),
    .rst        (RST),
    .capture    (capture),
    .spin_in    (SPIN_OUT),
    .dout_ready (DOUT_READY),
    .dout       (DOUT),
    .dout_valid (DOUT_VALID),
    .dout_last  (DOUT_LAST),
    .last_xfer  (last_xfer)
  );

endmodule
